pipe_sequencer: RTL and testbench

Central stall/flush controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB and their stage registers). It takes three inputs: load-use hazard detection, branch resolution from EXE, and the MEM-stage data-memory handshake. From these it generates per-stage freeze and flush controls, a one-cycle memory start strobe, a memory-timeout error, and saturating performance counters. Freeze and flush outputs are combinational from state and inputs. State, wait timer and counters are registered.

---
 rtl/pipe_sequencer.sv | 132 +++++++++++++
 tb/tb_pipe_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: stall/flush controller for the 5-stage ARM pipeline.
// It arbitrates a MEM-stage data-memory access, a taken branch from EXE and a
// load-use hazard from ID. The result is per-stage freeze/flush controls, a
// one-cycle memory start strobe, a sticky timeout error and saturating
// performance counters.
//
// Handshake: mem_start is a single-cycle request strobe. It is issued only on
// the RUN->MEM_WAIT transition. The access completes in the first MEM_WAIT
// cycle that has mem_ready=1, and the pipeline advances in that same cycle.
// mem_ready is ignored in every other cycle.
module pipe_sequencer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             back_freeze,
    output logic             mem_start,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] wait_timer;
    logic [TW-1:0] wait_timer_nxt;
    logic          run_eval;
    logic          branch_flush;

    assign state_dbg = state;

    // Next-state and control decode. Every control output is zero while rst is high.
    always_comb begin
        pc_freeze      = 1'b0;
        if_freeze      = 1'b0;
        if_flush       = 1'b0;
        id_flush       = 1'b0;
        back_freeze    = 1'b0;
        mem_start      = 1'b0;
        branch_flush   = 1'b0;
        run_eval       = 1'b0;
        state_nxt      = state;
        wait_timer_nxt = wait_timer;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (mem_req) begin
                        // Branch and hazard wait: EXE_Reg/ID_Reg hold them until release.
                        mem_start      = 1'b1;
                        pc_freeze      = 1'b1;
                        if_freeze      = 1'b1;
                        back_freeze    = 1'b1;
                        state_nxt      = ST_MEM_WAIT;
                        wait_timer_nxt = '0;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        // Release cycle behaves like RUN without a memory request.
                        run_eval  = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        pc_freeze      = 1'b1;
                        if_freeze      = 1'b1;
                        back_freeze    = 1'b1;
                        wait_timer_nxt = wait_timer + TW'(1);
                        if (wait_timer == TW'(MEM_TIMEOUT - 1))
                            state_nxt = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    pc_freeze   = 1'b1;
                    if_freeze   = 1'b1;
                    back_freeze = 1'b1;
                end
                default: state_nxt = ST_RUN;
            endcase

            if (run_eval) begin
                if (branch_taken) begin
                    // A taken branch wins over hazard: the hazarding instruction is flushed anyway.
                    if_flush     = 1'b1;
                    id_flush     = 1'b1;
                    branch_flush = 1'b1;
                end else if (hazard) begin
                    pc_freeze = 1'b1;
                    if_freeze = 1'b1;
                    id_flush  = 1'b1;
                end
            end
        end
    end

    // State, wait timer, sticky error and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            wait_timer <= '0;
            err        <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            wait_timer <= wait_timer_nxt;
            if (state_nxt == ST_ERROR)
                err <= 1'b1;
            if (pc_freeze && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed testbench for pipe_sequencer (MEM_TIMEOUT=4, CNT_W=3).
module tb_pipe_sequencer;

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERROR    = 2'd2;

    // ctl bit order: {pc_freeze, if_freeze, if_flush, id_flush, back_freeze, mem_start, err}
    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_START  = 7'b1100110;
    localparam logic [6:0] C_WAIT   = 7'b1100100;
    localparam logic [6:0] C_ERR    = 7'b1100101;
    localparam logic [6:0] C_HAZ    = 7'b1101000;
    localparam logic [6:0] C_BRANCH = 7'b0011000;

    logic       clk = 1'b0;
    logic       rst;
    logic       hazard, branch_taken, mem_req, mem_ready;
    logic       pc_freeze, if_freeze, if_flush, id_flush, back_freeze, mem_start, err;
    logic [2:0] stall_cnt, flush_cnt;
    logic [1:0] state_dbg;
    logic [6:0] ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_freeze, if_freeze, if_flush, id_flush, back_freeze, mem_start, err};

    pipe_sequencer #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_freeze(if_freeze), .if_flush(if_flush),
        .id_flush(id_flush), .back_freeze(back_freeze), .mem_start(mem_start),
        .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one clock; return at the falling edge where inputs are driven.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic h, input logic b, input logic q, input logic r);
        hazard = h; branch_taken = b; mem_req = q; mem_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 1);
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl0 got %b exp %b", ctl, C_IDLE); end
        cycle(); #1;
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl1 got %b exp %b", ctl, C_IDLE); end
        checks++;
        if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0);
        checks++;
        if (ctl !== C_IDLE || state_dbg !== S_RUN) begin
            errors++; $display("FAIL reset_release got %b st %0d exp %b st %0d", ctl, state_dbg, C_IDLE, S_RUN);
        end
        cycle(); #1;
        checks++;
        if (ctl !== C_IDLE || stall_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_idle got %b cnt %0d exp %b cnt 0", ctl, stall_cnt, C_IDLE);
        end
    endtask

    task automatic test_load_access();
        do_reset();
        drive(0, 0, 1, 0);
        checks++;
        if (ctl !== C_START) begin errors++; $display("FAIL load_c0 got %b exp %b", ctl, C_START); end
        for (int c = 1; c <= 2; c++) begin
            cycle(); drive(0, 0, 1, 0);
            checks++;
            if (ctl !== C_WAIT) begin errors++; $display("FAIL load_c%0d got %b exp %b", c, ctl, C_WAIT); end
        end
        cycle(); drive(0, 0, 1, 1);
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL load_release got %b exp %b", ctl, C_IDLE); end
        // Back-to-back: mem_req still high in the cycle after release.
        cycle(); drive(0, 0, 1, 0);
        checks++;
        if (ctl !== C_START || stall_cnt !== 3'd3) begin
            errors++; $display("FAIL back_to_back got %b cnt %0d exp %b cnt 3", ctl, stall_cnt, C_START);
        end
        cycle(); drive(0, 0, 1, 1);
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL b2b_release got %b exp %b", ctl, C_IDLE); end
        cycle(); drive(0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 3'd4 || state_dbg !== S_RUN) begin
            errors++; $display("FAIL load_stall_cnt got %0d st %0d exp 4 st %0d", stall_cnt, state_dbg, S_RUN);
        end
    endtask

    task automatic test_hazard_branch();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 0, 0);
            checks++;
            if (ctl !== C_HAZ) begin errors++; $display("FAIL hazard_c%0d got %b exp %b", c, ctl, C_HAZ); end
            cycle();
        end
        drive(1, 1, 0, 0);
        checks++;
        if (ctl !== C_BRANCH) begin errors++; $display("FAIL branch_beats_hazard got %b exp %b", ctl, C_BRANCH); end
        cycle(); drive(0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 3'd2 || flush_cnt !== 3'd1) begin
            errors++; $display("FAIL hazard_cnts got %0d/%0d exp 2/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_branch_in_mem();
        do_reset();
        drive(0, 1, 1, 0);
        checks++;
        if (ctl !== C_START) begin errors++; $display("FAIL bmem_c0 got %b exp %b", ctl, C_START); end
        cycle(); drive(0, 1, 1, 0);
        checks++;
        if (ctl !== C_WAIT) begin errors++; $display("FAIL bmem_c1 got %b exp %b", ctl, C_WAIT); end
        cycle(); drive(0, 1, 1, 1);
        checks++;
        if (ctl !== C_BRANCH) begin errors++; $display("FAIL bmem_release got %b exp %b", ctl, C_BRANCH); end
        cycle(); drive(0, 0, 0, 0);
        checks++;
        if (flush_cnt !== 3'd1 || stall_cnt !== 3'd2) begin
            errors++; $display("FAIL bmem_cnts got %0d/%0d exp flush 1 stall 2", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            cycle(); drive(0, 0, 1, 0);
        end
        checks++;
        if (ctl !== C_WAIT || state_dbg !== S_MEM_WAIT) begin
            errors++; $display("FAIL timeout_c4 got %b st %0d exp %b st %0d", ctl, state_dbg, C_WAIT, S_MEM_WAIT);
        end
        cycle(); drive(0, 0, 1, 0);
        checks++;
        if (ctl !== C_ERR || state_dbg !== S_ERROR) begin
            errors++; $display("FAIL timeout_c5 got %b st %0d exp %b st %0d", ctl, state_dbg, C_ERR, S_ERROR);
        end
        // mem_ready in ERROR is ignored.
        cycle(); drive(1, 1, 0, 1);
        checks++;
        if (ctl !== C_ERR) begin errors++; $display("FAIL error_sticky got %b exp %b", ctl, C_ERR); end
        rst = 1'b1; drive(0, 0, 0, 0);
        cycle(); rst = 1'b0; drive(0, 0, 0, 0);
        checks++;
        if (ctl !== C_IDLE || state_dbg !== S_RUN) begin
            errors++; $display("FAIL error_reset got %b st %0d exp %b st %0d", ctl, state_dbg, C_IDLE, S_RUN);
        end
        // mem_ready in MEM_WAIT cycle 4 is still accepted.
        drive(0, 0, 1, 0);
        for (int c = 1; c <= 3; c++) begin
            cycle(); drive(0, 0, 1, 0);
        end
        cycle(); drive(0, 0, 1, 1);
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL late_ready got %b exp %b", ctl, C_IDLE); end
        cycle(); drive(0, 0, 0, 0);
        checks++;
        if (err !== 1'b0 || state_dbg !== S_RUN || stall_cnt !== 3'd4) begin
            errors++; $display("FAIL late_ready_after got err %b st %0d cnt %0d exp 0 %0d 4", err, state_dbg, stall_cnt, S_RUN);
        end
        // Reset in the middle of MEM_WAIT leaves no access outstanding.
        drive(0, 0, 1, 0);
        cycle(); rst = 1'b1; drive(0, 0, 1, 0);
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL midwait_rst got %b exp %b", ctl, C_IDLE); end
        cycle(); rst = 1'b0; drive(0, 0, 0, 0);
        checks++;
        if (ctl !== C_IDLE || state_dbg !== S_RUN) begin
            errors++; $display("FAIL midwait_after got %b st %0d exp %b st %0d", ctl, state_dbg, C_IDLE, S_RUN);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 3'd7) begin errors++; $display("FAIL stall_sat got %0d exp 7", stall_cnt); end
        for (int c = 0; c < 9; c++) begin
            drive(0, 1, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0);
        checks++;
        if (flush_cnt !== 3'd7 || stall_cnt !== 3'd7) begin
            errors++; $display("FAIL flush_sat got %0d/%0d exp 7/7", flush_cnt, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_access();
        test_hazard_branch();
        test_branch_in_mem();
        test_timeout();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
